// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp constants for the traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_FLASH  = 2'b11
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  // FLASH shows only the yellow lamp, gated by the blink phase.
  function automatic logic [2:0] lamp_decode(input state_t st, input logic blink);
    logic [2:0] lamp;
    lamp = LAMP_OFF;
    case (st)
      ST_RED:    lamp = LAMP_RED;
      ST_GREEN:  lamp = LAMP_GREEN;
      ST_YELLOW: lamp = LAMP_YELLOW;
      ST_FLASH:  lamp = blink ? LAMP_YELLOW : LAMP_OFF;
      default:   lamp = LAMP_OFF;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: synchronous clear beats enable; o_tc flags cnt == i_limit.
module dwell_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_limit);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore traffic-light FSM with per-state dwell, pedestrian shortcut and flashing-yellow mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned RED_TICKS    = 4,
  parameter int unsigned GREEN_TICKS  = 6,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned MIN_GREEN    = 2,
  parameter int unsigned FLASH_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] o,
  output logic [1:0] state,
  output logic       ped_ack
);

  localparam logic [CNT_W-1:0] LIM_RED    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] LIM_GREEN  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] LIM_FLASH  = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_G_M1   = CNT_W'(MIN_GREEN - 1);

  state_t           r_state;
  logic             r_blink;
  logic             r_ped_pend;
  logic             r_ped_ack;

  state_t           w_nxt_state;
  logic             w_blink_nxt;
  logic             w_pend_nxt;
  logic             w_ack_nxt;
  logic             w_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;

  dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RED;
      r_blink    <= 1'b1;
      r_ped_pend <= 1'b0;
      r_ped_ack  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_blink    <= w_blink_nxt;
      r_ped_pend <= w_pend_nxt;
      r_ped_ack  <= w_ack_nxt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_blink_nxt = r_blink;
    w_pend_nxt  = r_ped_pend | ped_req;
    w_ack_nxt   = 1'b0;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;

    case (r_state)
      ST_RED:    w_limit = LIM_RED;
      ST_GREEN:  w_limit = LIM_GREEN;
      ST_YELLOW: w_limit = LIM_YELLOW;
      ST_FLASH:  w_limit = LIM_FLASH;
      default:   w_limit = LIM_RED;
    endcase

    if (r_state == ST_FLASH) begin
      // FLASH keeps blinking even while en is low.
      if (!flash) begin
        w_nxt_state = ST_RED;
        w_clr       = 1'b1;
        w_blink_nxt = 1'b1;
      end else if (w_tc) begin
        w_clr       = 1'b1;
        w_blink_nxt = ~r_blink;
      end else begin
        w_cnt_en    = 1'b1;
      end
    end else if (flash) begin
      w_nxt_state = ST_FLASH;
      w_clr       = 1'b1;
      w_blink_nxt = 1'b1;
      w_pend_nxt  = 1'b0;
    end else if (en) begin
      if (r_state == ST_GREEN && r_ped_pend && w_cnt >= MIN_G_M1) begin
        w_nxt_state = ST_YELLOW;
      end else if (w_tc) begin
        case (r_state)
          ST_RED:    w_nxt_state = ST_GREEN;
          ST_GREEN:  w_nxt_state = ST_YELLOW;
          ST_YELLOW: w_nxt_state = ST_RED;
          default:   w_nxt_state = ST_RED;
        endcase
      end

      if (w_nxt_state != r_state) w_clr = 1'b1;
      else                        w_cnt_en = 1'b1;

      // Entering YELLOW services the request; a same-cycle new request stays pending.
      if (w_nxt_state == ST_YELLOW && r_state != ST_YELLOW && r_ped_pend) begin
        w_pend_nxt = ped_req;
        w_ack_nxt  = 1'b1;
      end
    end
  end

  assign o       = lamp_decode(r_state, r_blink);
  assign state   = r_state;
  assign ped_ack = r_ped_ack;

endmodule
